// File: rtl/lsu_mem.sv
// Load/store unit M-stage memory sequencer: one outstanding access, lane-shifted stores,
// sign/zero-extended loads. Optional build macro MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [2:0]  funct3_M,
  input  logic [63:0] alu_out_M,
  input  logic [63:0] rs2_data_M,
  output logic        waiting,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  output logic [63:0] ld_data_W,
  output logic        ld_valid,
  output logic        misalign_exc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] ld_data_q, ld_data_d;

  logic        access;
  logic        is_store;
  logic [2:0]  keep_mask;
  logic [7:0]  size_mask;
  logic [2:0]  offset;
  logic        trap;
  logic [63:0] rdata_shifted;
  logic [63:0] load_ext;

  // A simultaneous read and write is treated as a store.
  assign access   = mem_read_M | mem_write_M;
  assign is_store = mem_write_M;

  // keep_mask selects the address offset bits that are legal for the access size.
  always_comb begin
    keep_mask = 3'b111;
    size_mask = 8'h01;
    case (funct3_M[1:0])
      2'd0: begin keep_mask = 3'b111; size_mask = 8'h01; end
      2'd1: begin keep_mask = 3'b110; size_mask = 8'h03; end
      2'd2: begin keep_mask = 3'b100; size_mask = 8'h0F; end
      default: begin keep_mask = 3'b000; size_mask = 8'hFF; end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign offset = alu_out_M[2:0];
  assign trap   = |(alu_out_M[2:0] & ~keep_mask);
`else
  assign offset = alu_out_M[2:0] & keep_mask;
  assign trap   = 1'b0;
`endif

  assign dmem_addr  = {alu_out_M[63:3], 3'b000};
  assign dmem_we    = is_store;
  assign dmem_wdata = rs2_data_M << {offset, 3'b000};
  assign dmem_wstrb = size_mask << offset;

  assign rdata_shifted = dmem_rdata >> {offset, 3'b000};

  always_comb begin
    load_ext = rdata_shifted;
    case (funct3_M)
      3'd0:    load_ext = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
      3'd1:    load_ext = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'd2:    load_ext = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
      3'd4:    load_ext = {56'd0, rdata_shifted[7:0]};
      3'd5:    load_ext = {48'd0, rdata_shifted[15:0]};
      3'd6:    load_ext = {32'd0, rdata_shifted[31:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ld_data_d = ld_data_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          if (trap) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
`ifdef MISALIGN_TRAP_EN
          misalign_d = trap;
`endif
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (is_store) begin
            state_d = DONE;
          end else if (dmem_rvalid) begin
            // Response in the grant cycle skips RESP entirely.
            ld_data_d = load_ext;
            state_d   = DONE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          ld_data_d = load_ext;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ld_data_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      ld_data_q <= ld_data_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_exc = (state_q == DONE) & misalign_q;
`else
  assign misalign_exc = 1'b0;
`endif

  assign dmem_req  = (state_q == REQ);
  assign waiting   = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == RESP);
  assign ld_valid  = (state_q == DONE);
  assign ld_data_W = ld_data_q;

endmodule
